// File: rtl/mm_job_sched_if.sv
// mm_job_sched_if: command handshake carrying one matmul job (M1, M2, M3)
interface mm_job_sched_if #(
    parameter int MATRIXSIZE_W = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [MATRIXSIZE_W-1:0] cmd_M1;
    logic [MATRIXSIZE_W-1:0] cmd_M2;
    logic [MATRIXSIZE_W-1:0] cmd_M3;
    modport master (output cmd_valid, cmd_M1, cmd_M2, cmd_M3, input cmd_ready);
    modport slave (input cmd_valid, cmd_M1, cmd_M2, cmd_M3, output cmd_ready);
endinterface

// File: rtl/mm_job_sched.sv
// mm_job_sched: validates a matmul job, derives tile bounds, gates the array controller and reports done/err
module mm_job_sched #(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int DRAIN_CYC    = 8,
    parameter int TIMEOUT      = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    mm_job_sched_if.slave           cmd,
    input  logic                    abort,
    input  logic                    last_init,
    output logic                    ctl_rst,
    output logic [MATRIXSIZE_W-1:0] M2,
    output logic [MATRIXSIZE_W-1:0] M1dN1,
    output logic [MATRIXSIZE_W-1:0] M3dN2,
    output logic [MATRIXSIZE_W-1:0] M1xM3dN1xN2,
    output logic [MATRIXSIZE_W-1:0] patch_cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2:0]              err_code
);
    localparam int W    = MATRIXSIZE_W;
    localparam int L1   = $clog2(N1);
    localparam int L2   = $clog2(N2);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int DR_W = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MULT, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      w_code;
    logic [W-1:0]    r_m1;
    logic [W-1:0]    r_m2;
    logic [W-1:0]    r_m3;
    logic [WD_W-1:0] r_wd;
    logic [DR_W-1:0] r_drain;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_cnt_inc;
    logic            w_bad_dim;
    logic            w_bad_div;

    assign w_prod    = {{W{1'b0}}, M1dN1} * {{W{1'b0}}, M3dN2};
    assign w_cnt_inc = patch_cnt + W'(1);
    assign w_bad_dim = (r_m1 == '0) || (r_m2 < W'(2)) || (r_m3 == '0);
    assign w_bad_div = ((r_m1 & W'(N1 - 1)) != '0) || ((r_m3 & W'(N2 - 1)) != '0);

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next state and error code; abort overrides every other exit from an active state
    always_comb begin
        w_next = r_state;
        w_code = 3'd0;
        case (r_state)
            S_IDLE:  w_next = cmd.cmd_valid ? S_CHECK : S_IDLE;
            S_CHECK: begin
                if (abort)          begin w_next = S_ERR; w_code = 3'd5; end
                else if (w_bad_dim) begin w_next = S_ERR; w_code = 3'd1; end
                else if (w_bad_div) begin w_next = S_ERR; w_code = 3'd2; end
                else                      w_next = S_MULT;
            end
            S_MULT: begin
                if (abort)                      begin w_next = S_ERR; w_code = 3'd5; end
                else if (w_prod[2*W-1:W] != '0) begin w_next = S_ERR; w_code = 3'd3; end
                else                                  w_next = S_RUN;
            end
            S_RUN: begin
                if (abort)                                       begin w_next = S_ERR; w_code = 3'd5; end
                else if (last_init && w_cnt_inc == M1xM3dN1xN2)        w_next = S_DRAIN;
                else if (!last_init && r_wd == WD_W'(TIMEOUT - 1)) begin w_next = S_ERR; w_code = 3'd4; end
            end
            S_DRAIN: begin
                if (abort)                                begin w_next = S_ERR; w_code = 3'd5; end
                else if (r_drain == DR_W'(DRAIN_CYC - 1))       w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // handshake and busy decode straight from the state register
    always_comb begin
        cmd.cmd_ready = (r_state == S_IDLE) && !rst;
        busy          = r_state != S_IDLE;
    end

    // job datapath, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m1        <= '0;
            r_m2        <= '0;
            r_m3        <= '0;
            M2          <= '0;
            M1dN1       <= '0;
            M3dN2       <= '0;
            M1xM3dN1xN2 <= '0;
            patch_cnt   <= '0;
            r_wd        <= '0;
            r_drain     <= '0;
            ctl_rst     <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 3'd0;
        end else begin
            if (r_state == S_IDLE && cmd.cmd_valid) begin
                r_m1      <= cmd.cmd_M1;
                r_m2      <= cmd.cmd_M2;
                r_m3      <= cmd.cmd_M3;
                patch_cnt <= '0;
            end
            if (r_state == S_CHECK && w_next == S_MULT) begin
                M2    <= r_m2;
                M1dN1 <= r_m1 >> L1;
                M3dN2 <= r_m3 >> L2;
            end
            if (r_state == S_MULT && w_next == S_RUN) M1xM3dN1xN2 <= w_prod[W-1:0];
            if (r_state == S_RUN && !abort && last_init && patch_cnt != M1xM3dN1xN2) patch_cnt <= w_cnt_inc;
            r_wd     <= (r_state == S_RUN && !last_init) ? r_wd + WD_W'(1) : '0;
            r_drain  <= (r_state == S_DRAIN) ? r_drain + DR_W'(1) : '0;
            ctl_rst  <= !(w_next == S_RUN || w_next == S_DRAIN);
            done     <= w_next == S_DONE;
            err      <= w_next == S_ERR;
            err_code <= (w_next == S_ERR) ? w_code : 3'd0;
        end
    end
endmodule

// File: tb/tb_mm_job_sched.sv
// tb_mm_job_sched: directed scenario checks of the matmul job sequencer
module tb_mm_job_sched;
    localparam int W  = 16;
    localparam int DC = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic last_init = 1'b0;
    logic ctl_rst, busy, done, err;
    logic [2:0] err_code;
    logic [W-1:0] M2, M1dN1, M3dN2, M1xM3dN1xN2, patch_cnt;
    int n_cmp = 0;
    int n_bad = 0;

    mm_job_sched_if #(.MATRIXSIZE_W(W)) cmd_if ();

    mm_job_sched #(.N1(4), .N2(4), .MATRIXSIZE_W(W), .DRAIN_CYC(DC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cmd(cmd_if.slave), .abort(abort), .last_init(last_init),
        .ctl_rst(ctl_rst), .M2(M2), .M1dN1(M1dN1), .M3dN2(M3dN2), .M1xM3dN1xN2(M1xM3dN1xN2),
        .patch_cnt(patch_cnt), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [W-1:0] m1, input logic [W-1:0] m2, input logic [W-1:0] m3);
        int n = 0;
        while (!cmd_if.cmd_ready && n < 50) begin tick(); n++; end
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL start_ready: got %b want 1", cmd_if.cmd_ready); end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_M1 = m1; cmd_if.cmd_M2 = m2; cmd_if.cmd_M3 = m3;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic pulse();
        last_init = 1'b1;
        tick();
        last_init = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (cmd_if.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", cmd_if.cmd_ready); end
        n_cmp++; if (ctl_rst !== 1'b1) begin n_bad++; $display("FAIL rst_ctl_rst: got %b want 1", ctl_rst); end
        n_cmp++; if ({busy, done, err, err_code} !== 6'd0) begin n_bad++; $display("FAIL rst_flags: got %b want 000000", {busy, done, err, err_code}); end
        n_cmp++; if ({patch_cnt, M2, M1dN1, M3dN2, M1xM3dN1xN2} !== '0) begin n_bad++; $display("FAIL rst_dims: got %0h want 0", {patch_cnt, M2, M1dN1, M3dN2, M1xM3dN1xN2}); end
        rst = 1'b0;
        tick();
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", cmd_if.cmd_ready); end
    endtask

    task automatic test_normal();
        int n;
        start_job(16'd8, 16'd4, 16'd8);
        n_cmp++; if ({busy, cmd_if.cmd_ready, ctl_rst} !== 3'b101) begin n_bad++; $display("FAIL norm_t1: got %b want 101", {busy, cmd_if.cmd_ready, ctl_rst}); end
        tick();
        n_cmp++; if ({M1dN1, M3dN2} !== {16'd2, 16'd2}) begin n_bad++; $display("FAIL norm_div: got %0d/%0d want 2/2", M1dN1, M3dN2); end
        n_cmp++; if (ctl_rst !== 1'b1) begin n_bad++; $display("FAIL norm_t2_ctl: got %b want 1", ctl_rst); end
        tick();
        n_cmp++; if (ctl_rst !== 1'b0) begin n_bad++; $display("FAIL norm_t3_ctl: got %b want 0", ctl_rst); end
        n_cmp++; if ({M2, M1xM3dN1xN2} !== {16'd4, 16'd4}) begin n_bad++; $display("FAIL norm_m2_total: got %0d/%0d want 4/4", M2, M1xM3dN1xN2); end
        pulse();
        n_cmp++; if (patch_cnt !== 16'd1) begin n_bad++; $display("FAIL norm_cnt1: got %0d want 1", patch_cnt); end
        tick();
        pulse(); tick();
        pulse();
        n_cmp++; if (patch_cnt !== 16'd3) begin n_bad++; $display("FAIL norm_cnt3: got %0d want 3", patch_cnt); end
        pulse();
        last_init = 1'b1;
        tick();
        last_init = 1'b0;
        n = 1;
        while (!done && n < 30) begin tick(); n++; end
        n_cmp++; if (n !== DC) begin n_bad++; $display("FAIL norm_drain_len: got %0d want %0d", n, DC); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL norm_done: got %b want 1", done); end
        n_cmp++; if (patch_cnt !== 16'd4) begin n_bad++; $display("FAIL norm_cnt_final: got %0d want 4", patch_cnt); end
        n_cmp++; if (ctl_rst !== 1'b1) begin n_bad++; $display("FAIL norm_done_ctl: got %b want 1", ctl_rst); end
        tick();
        n_cmp++; if ({done, cmd_if.cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL norm_after: got %b want 01", {done, cmd_if.cmd_ready}); end
    endtask

    task automatic test_checks();
        logic [W-1:0] m1 [4] = '{16'd6, 16'd6, 16'd8, 16'd8};
        logic [W-1:0] m2 [4] = '{16'd4, 16'd1, 16'd0, 16'd4};
        logic [W-1:0] m3 [4] = '{16'd8, 16'd8, 16'd8, 16'd0};
        logic [2:0]   ec [4] = '{3'd2, 3'd1, 3'd1, 3'd1};
        for (int i = 0; i < 4; i++) begin
            start_job(m1[i], m2[i], m3[i]);
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL chk%0d_t1_err: got %b want 0", i, err); end
            tick();
            n_cmp++; if ({err, err_code, ctl_rst} !== {1'b1, ec[i], 1'b1}) begin n_bad++; $display("FAIL chk%0d_t2: got err=%b code=%0d ctl=%b want 1/%0d/1", i, err, err_code, ctl_rst, ec[i]); end
            tick();
            n_cmp++; if ({err, cmd_if.cmd_ready, ctl_rst} !== 3'b011) begin n_bad++; $display("FAIL chk%0d_t3: got %b want 011", i, {err, cmd_if.cmd_ready, ctl_rst}); end
        end
    endtask

    task automatic test_overflow();
        start_job(16'd1024, 16'd4, 16'd1024);
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovf_t2_err: got %b want 0", err); end
        n_cmp++; if ({M1dN1, M3dN2} !== {16'd256, 16'd256}) begin n_bad++; $display("FAIL ovf_div: got %0d/%0d want 256/256", M1dN1, M3dN2); end
        tick();
        n_cmp++; if ({err, err_code, ctl_rst} !== {1'b1, 3'd3, 1'b1}) begin n_bad++; $display("FAIL ovf_t3: got err=%b code=%0d ctl=%b want 1/3/1", err, err_code, ctl_rst); end
        tick();
    endtask

    task automatic test_watchdog();
        start_job(16'd4, 16'd4, 16'd4);
        tick(); tick();
        for (int i = 1; i < TO; i++) tick();
        n_cmp++; if ({err, ctl_rst} !== 2'b00) begin n_bad++; $display("FAIL wd_cycle20: got %b want 00", {err, ctl_rst}); end
        tick();
        n_cmp++; if ({err, err_code, ctl_rst} !== {1'b1, 3'd4, 1'b1}) begin n_bad++; $display("FAIL wd_cycle21: got err=%b code=%0d ctl=%b want 1/4/1", err, err_code, ctl_rst); end
        tick();
        n_cmp++; if ({ctl_rst, cmd_if.cmd_ready} !== 2'b11) begin n_bad++; $display("FAIL wd_after: got %b want 11", {ctl_rst, cmd_if.cmd_ready}); end
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        start_job(16'd8, 16'd4, 16'd8);
        tick(); tick();
        pulse();
        last_init = 1'b1; abort = 1'b1;
        tick();
        last_init = 1'b0; abort = 1'b0;
        n_cmp++; if ({err, err_code, done} !== {1'b1, 3'd5, 1'b0}) begin n_bad++; $display("FAIL abort_err: got err=%b code=%0d done=%b want 1/5/0", err, err_code, done); end
        n_cmp++; if (patch_cnt !== 16'd1) begin n_bad++; $display("FAIL abort_cnt: got %0d want 1", patch_cnt); end
        for (int i = 0; i < 6; i++) begin tick(); seen |= done; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", seen); end
    endtask

    task automatic test_rst_drain();
        logic seen = 1'b0;
        start_job(16'd4, 16'd4, 16'd4);
        tick(); tick();
        pulse();
        tick();
        n_cmp++; if ({busy, ctl_rst, patch_cnt} !== {1'b1, 1'b0, 16'd1}) begin n_bad++; $display("FAIL rd_in_drain: got %b want 1 0 0001", {busy, ctl_rst, patch_cnt}); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({busy, ctl_rst, done, cmd_if.cmd_ready} !== 4'b0100) begin n_bad++; $display("FAIL rd_after_rst: got %b want 0100", {busy, ctl_rst, done, cmd_if.cmd_ready}); end
        rst = 1'b0;
        for (int i = 0; i < DC + 2; i++) begin tick(); seen |= done; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rd_no_done: got %b want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] m1 [2] = '{16'd4, 16'd12};
        logic [W-1:0] m2 [2] = '{16'd2, 16'd3};
        logic [W-1:0] m3 [2] = '{16'd8, 16'd4};
        logic [W-1:0] tot [2] = '{16'd2, 16'd3};
        int n;
        for (int j = 0; j < 2; j++) begin
            start_job(m1[j], m2[j], m3[j]);
            tick(); tick();
            n_cmp++; if ({M2, M1xM3dN1xN2} !== {m2[j], tot[j]}) begin n_bad++; $display("FAIL b2b%0d_dims: got %0d/%0d want %0d/%0d", j, M2, M1xM3dN1xN2, m2[j], tot[j]); end
            for (int k = 0; k < tot[j]; k++) pulse();
            n = 0;
            while (!done && n < 30) begin tick(); n++; end
            n_cmp++; if ({done, n} !== {1'b1, DC}) begin n_bad++; $display("FAIL b2b%0d_done: got done=%b after %0d want 1 after %0d", j, done, n, DC); end
            n_cmp++; if (patch_cnt !== tot[j]) begin n_bad++; $display("FAIL b2b%0d_cnt: got %0d want %0d", j, patch_cnt, tot[j]); end
            tick();
        end
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_M1 = '0; cmd_if.cmd_M2 = '0; cmd_if.cmd_M3 = '0;
        test_reset();
        test_normal();
        test_checks();
        test_overflow();
        test_watchdog();
        test_abort();
        test_rst_drain();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
